// File: rtl/alu_uart_if_pkg.sv
// Shared definitions for the ALU <-> UART bridge: default widths, FSM state
// encoding and the ALU opcode constants understood by the companion ALU.
package alu_uart_if_pkg;

   localparam int N_BITS_DEF = 8;
   localparam int N_OP_DEF   = 6;

   // ALU opcodes (low N_OP bits of the received opcode byte)
   localparam logic [N_OP_DEF-1:0] OP_SRL = 6'h02;
   localparam logic [N_OP_DEF-1:0] OP_SRA = 6'h03;
   localparam logic [N_OP_DEF-1:0] OP_ADD = 6'h20;
   localparam logic [N_OP_DEF-1:0] OP_SUB = 6'h22;
   localparam logic [N_OP_DEF-1:0] OP_AND = 6'h24;
   localparam logic [N_OP_DEF-1:0] OP_OR  = 6'h25;
   localparam logic [N_OP_DEF-1:0] OP_XOR = 6'h26;
   localparam logic [N_OP_DEF-1:0] OP_NOR = 6'h27;

   typedef enum logic [2:0] {
      ST_GET_A   = 3'd0,
      ST_GET_B   = 3'd1,
      ST_GET_OP  = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } state_t;

endpackage

// File: rtl/alu_uart_if.sv
// Bridge between a UART and a combinational ALU: collects operand A, operand B
// and an opcode from three received bytes, lets the ALU settle for one cycle,
// then hands the result byte to the UART transmitter and waits for it to go.
module alu_uart_if
   import alu_uart_if_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEF,
   parameter int N_OP   = N_OP_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_done,
   input  logic [N_BITS-1:0] rx_data,
   input  logic              tx_done,
   input  logic [N_BITS-1:0] alu_result,
   output logic [N_BITS-1:0] alu_a,
   output logic [N_BITS-1:0] alu_b,
   output logic [N_OP-1:0]   alu_op,
   output logic              tx_start,
   output logic [N_BITS-1:0] tx_data,
   output logic              busy,
   output logic [N_BITS-1:0] drop_cnt
);

   state_t state;
   state_t state_nxt;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_GET_A;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; tx_done only matters in WAIT_TX, and an rx_done arriving
   // together with it is dropped rather than taken as the next operand A
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_GET_A:   if (rx_done) state_nxt = ST_GET_B;
         ST_GET_B:   if (rx_done) state_nxt = ST_GET_OP;
         ST_GET_OP:  if (rx_done) state_nxt = ST_EXEC;
         ST_EXEC:    state_nxt = ST_SEND;
         ST_SEND:    state_nxt = ST_WAIT_TX;
         ST_WAIT_TX: if (tx_done) state_nxt = ST_GET_A;
         default:    state_nxt = ST_GET_A;
      endcase
   end

   // Moore outputs decoded from the current state
   always_comb begin
      tx_start = (state == ST_SEND);
      busy     = (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT_TX);
   end

   // Operand and opcode capture; values persist until the next transaction overwrites them
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
      end else if (rx_done) begin
         case (state)
            ST_GET_A:  alu_a  <= rx_data;
            ST_GET_B:  alu_b  <= rx_data;
            ST_GET_OP: alu_op <= rx_data[N_OP-1:0];
            default:   ;
         endcase
      end
   end

   // Result capture at the end of EXEC, once the ALU has had a full cycle to settle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data <= '0;
      end else if (state == ST_EXEC) begin
         tx_data <= alu_result;
      end
   end

   // Saturating count of bytes that arrived while a result was in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (rx_done && busy && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + N_BITS'(1);
      end
   end

endmodule
